// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped 8N1 UART transmitter with TX FIFO and frame-done interrupt
module uart_tx_peripheral #(
    parameter int unsigned BAUD_DIV   = 10416,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_TXD   = 32'h4000_0018,
    parameter logic [31:0] ADDR_CON   = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        peri_cre_i,
    input  logic        peri_cwe_i,
    input  logic [31:0] peri_addr_i,
    input  logic [31:0] peri_wdata_i,
    output logic [31:0] peri_rdata_o,
    output logic        uart_txd_o,
    output logic        intreq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [BW-1:0] bcnt, bcnt_nx;
    logic [2:0]    bidx, bidx_nx;
    logic [7:0]    shreg, shreg_nx, last_byte;
    logic          txd_nx, int_en, done, ovf, set_done;
    logic          wr_txd, wr_con, full, empty, push, pop, busy;
    logic          unused_wdata;

    assign wr_txd       = peri_cwe_i && peri_addr_i == ADDR_TXD;
    assign wr_con       = peri_cwe_i && peri_addr_i == ADDR_CON;
    assign full         = count == DEPTH;
    assign empty        = count == '0;
    assign push         = wr_txd && (!full || pop);
    assign busy         = state != IDLE;
    assign intreq_o     = int_en & done;
    assign unused_wdata = ^peri_wdata_i[31:8];
    assign peri_rdata_o = !peri_cre_i ? 32'h0 :
                          peri_addr_i == ADDR_TXD ? {24'h0, last_byte} :
                          peri_addr_i == ADDR_CON ? {27'h0, empty, ovf, busy, done, int_en} : 32'h0;

    // FIFO pointers and occupancy; a push while full is only taken when a pop frees a slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= push ? wptr + 1'b1 : wptr;
            rptr  <= pop ? rptr + 1'b1 : rptr;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= peri_wdata_i[7:0];
    end

    // Control/status flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_en    <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            last_byte <= 8'h0;
        end else begin
            int_en    <= wr_con ? peri_wdata_i[0] : int_en;
            done      <= set_done | (done & ~(wr_con & peri_wdata_i[1]));
            ovf       <= (wr_txd & full & ~pop) | (ovf & ~(wr_con & peri_wdata_i[3]));
            last_byte <= wr_txd ? peri_wdata_i[7:0] : last_byte;
        end
    end

    // Serialiser state; the line is registered from the next-state value so it changes with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bcnt       <= '0;
            bidx       <= '0;
            shreg      <= '0;
            uart_txd_o <= 1'b1;
        end else begin
            state      <= state_nx;
            bcnt       <= bcnt_nx;
            bidx       <= bidx_nx;
            shreg      <= shreg_nx;
            uart_txd_o <= txd_nx;
        end
    end

    // Next-state logic: one bit period per state (eight in DATA), pop only from IDLE
    always_comb begin
        state_nx = state;
        bcnt_nx  = busy ? bcnt - 1'b1 : bcnt;
        bidx_nx  = bidx;
        shreg_nx = shreg;
        pop      = 1'b0;
        set_done = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop      = 1'b1;
                shreg_nx = mem[rptr];
                bcnt_nx  = BAUD_MAX;
                state_nx = START;
            end
            START: if (bcnt == '0) begin
                bcnt_nx  = BAUD_MAX;
                bidx_nx  = 3'd0;
                state_nx = DATA;
            end
            DATA: if (bcnt == '0) begin
                bcnt_nx  = BAUD_MAX;
                shreg_nx = shreg >> 1;
                bidx_nx  = bidx + 3'd1;
                state_nx = bidx == 3'd7 ? STOP : DATA;
            end
            STOP: if (bcnt == '0) begin
                set_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        txd_nx = state_nx == START ? 1'b0 : state_nx == DATA ? shreg_nx[0] : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_peripheral.sv
// tb_uart_tx_peripheral: scoreboard bench decoding the serial line against the bytes written
module tb_uart_tx_peripheral;
    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] CON = 32'h4000_0020;
    localparam logic [31:0] UNM = 32'h4000_001C;

    logic        clk = 0, rst = 0, cre = 0, cwe = 0;
    logic [31:0] addr = 0, wdata = 0, rdata;
    logic        txd, intreq;
    int          cyc = 0, checks = 0, errors = 0, frames = 0;
    bit          abort = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    uart_tx_peripheral #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .peri_cre_i(cre), .peri_cwe_i(cwe), .peri_addr_i(addr),
        .peri_wdata_i(wdata), .peri_rdata_o(rdata), .uart_txd_o(txd), .intreq_o(intreq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; cwe = 1;
        @(negedge clk);
        cwe = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; cre = 1;
        #1 d = rdata;
        cre = 0;
    endtask

    // Decodes frames by sampling mid-bit and compares each against the scoreboard
    task automatic monitor();
        logic [7:0] got;
        logic       sb, pb;
        forever begin
            @(negedge clk);
            if (rst && txd === 1'b0) begin
                frames++;
                start_q.push_back(cyc);
                repeat (2) @(negedge clk);
                sb = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    got[i] = txd;
                end
                repeat (4) @(negedge clk);
                pb = txd;
                if (abort) abort = 0;
                else begin
                    checks++;
                    if (sb !== 1'b0 || pb !== 1'b1) begin
                        errors++;
                        $display("FAIL framing: start %b stop %b, required 0 and 1", sb, pb);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: got %h, nothing pending", got);
                    end else if (got !== exp_q[0]) begin
                        errors++;
                        $display("FAIL frame_data: got %h required %h", got, exp_q.pop_front());
                    end else void'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || intreq !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins: txd %b intreq %b, required 1 0", txd, intreq);
        end
        rd(CON, v);
        checks++;
        if (v !== 32'h10) begin errors++; $display("FAIL reset_con: got %h required 00000010", v); end
        rd(TXD, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_txd: got %h required 00000000", v); end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] v;
        wr(TXD, 32'h55);
        exp_q.push_back(8'h55);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL latency_early: txd %b required 1", txd); end
        @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL latency_fall: txd %b required 0", txd); end
        repeat (9) @(negedge clk);
        rd(CON, v);
        checks++;
        if (v !== 32'h14) begin errors++; $display("FAIL busy_con: got %h required 00000014", v); end
        wait_drain("basic");
        rd(CON, v);
        checks++;
        if (v !== 32'h12) begin errors++; $display("FAIL done_con: got %h required 00000012", v); end
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        wr(CON, 32'h2);
        wr(CON, 32'h1);
        wr(TXD, 32'hA3);
        exp_q.push_back(8'hA3);
        repeat (40) @(negedge clk);
        checks++;
        if (intreq !== 1'b0) begin errors++; $display("FAIL int_early: intreq %b required 0", intreq); end
        @(negedge clk);
        checks++;
        if (intreq !== 1'b1) begin errors++; $display("FAIL int_rise: intreq %b required 1", intreq); end
        rd(CON, v);
        checks++;
        if (v !== 32'h13) begin errors++; $display("FAIL int_con: got %h required 00000013", v); end
        wr(CON, 32'h3);
        checks++;
        if (intreq !== 1'b0) begin errors++; $display("FAIL int_clear: intreq %b required 0", intreq); end
        wr(CON, 32'h0);
        wait_drain("interrupt");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
        logic [31:0] v;
        start_q.delete();
        for (int i = 0; i < 6; i++) begin
            wr(TXD, {24'h0, b[i]});
            if (i < 5) exp_q.push_back(b[i]);
        end
        rd(CON, v);
        checks++;
        if (v !== 32'h0C) begin errors++; $display("FAIL ovf_con: got %h required 0000000c", v); end
        wait_drain("back_to_back");
        checks++;
        if (start_q.size() != 5) begin
            errors++;
            $display("FAIL frame_count: got %0d required 5", start_q.size());
        end else for (int i = 1; i < 5; i++) begin
            checks++;
            if (start_q[i] - start_q[i-1] != 41) begin
                errors++;
                $display("FAIL spacing: frame %0d got %0d cycles required 41", i, start_q[i] - start_q[i-1]);
            end
        end
        rd(CON, v);
        checks++;
        if (v !== 32'h1A) begin errors++; $display("FAIL b2b_con: got %h required 0000001a", v); end
        wr(CON, 32'hA);
        rd(CON, v);
        checks++;
        if (v !== 32'h10) begin errors++; $display("FAIL clear_con: got %h required 00000010", v); end
    endtask

    task automatic test_full_pop();
        logic [31:0] v;
        for (int i = 0; i < 5; i++) begin
            wr(TXD, 32'hC1 + i);
            exp_q.push_back(8'(8'hC1 + i));
        end
        repeat (37) @(negedge clk);
        wr(TXD, 32'hC6);
        exp_q.push_back(8'hC6);
        rd(CON, v);
        checks++;
        if (v[4:3] !== 2'b00) begin
            errors++;
            $display("FAIL full_pop_con: empty/ovf got %b required 00", v[4:3]);
        end
        wait_drain("full_pop");
        rd(CON, v);
        checks++;
        if (v !== 32'h12) begin errors++; $display("FAIL full_pop_end: got %h required 00000012", v); end
        wr(CON, 32'h2);
    endtask

    task automatic test_readback();
        logic [31:0] v;
        rd(UNM, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h required 00000000", v); end
        wr(UNM, 32'hFF);
        rd(CON, v);
        checks++;
        if (v !== 32'h10) begin errors++; $display("FAIL unmapped_wr: got %h required 00000010", v); end
        wr(TXD, 32'h1FF);
        exp_q.push_back(8'hFF);
        addr = TXD;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL no_cre: got %h required 00000000", rdata); end
        rd(TXD, v);
        checks++;
        if (v !== 32'hFF) begin errors++; $display("FAIL txd_rd: got %h required 000000ff", v); end
        wait_drain("readback");
        wr(CON, 32'h2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int f0;
        wr(TXD, 32'h3C);
        wr(TXD, 32'h81);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h81);
        repeat (17) @(negedge clk);
        abort = 1;
        rst = 0;
        #1;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL abort_txd: txd %b required 1", txd); end
        rd(CON, v);
        checks++;
        if (v !== 32'h10) begin errors++; $display("FAIL abort_con: got %h required 00000010", v); end
        exp_q.delete();
        f0 = frames;
        @(negedge clk);
        rst = 1;
        repeat (60) @(negedge clk);
        checks++;
        if (frames != f0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: %0d new frames txd %b, required 0 and 1", frames - f0, txd);
        end
        rd(CON, v);
        checks++;
        if (v !== 32'h10) begin errors++; $display("FAIL after_reset_con: got %h required 00000010", v); end
    endtask

    initial begin
        fork monitor(); join_none
        test_reset();
        test_basic();
        test_interrupt();
        test_back_to_back();
        test_full_pop();
        test_readback();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
